// File: rtl/seq_gen_pkg.sv
// Shared types, constants and width helpers for the seq_gen serial pattern transmitter.
package seq_gen_pkg;

  localparam int unsigned STATE_W = 2;
  localparam int unsigned REPS_W  = 4;

  localparam logic [STATE_W-1:0] S_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] S_SHIFT = 2'd1;
  localparam logic [STATE_W-1:0] S_GAP   = 2'd2;
  localparam logic [STATE_W-1:0] S_DONE  = 2'd3;

  // Canonical pattern recognised by the lab's detectors.
  localparam logic [3:0] PAT_1101 = 4'b1101;

  // Bits needed to hold a length of 0..width.
  function automatic int unsigned len_w(input int unsigned width);
    return $clog2(width + 1);
  endfunction

  // Bits needed for a down-counter holding 0..n-1 (at least one bit).
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_gen_shreg.sv
// MSB-aligned loadable shift register with a bit down-counter; last_c flags the final bit.
module seq_gen_shreg
  import seq_gen_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] load_data,
  input  logic [LEN_W-1:0] load_len,
  output logic             msb,
  output logic             last_c
);

  logic [WIDTH-1:0] sr_d, sr_q;
  logic [LEN_W-1:0] cnt_d, cnt_q;

  // Load takes priority over shift.
  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (load) begin
      sr_d  = load_data;
      cnt_d = load_len;
    end else if (shift) begin
      sr_d  = sr_q << 1;
      cnt_d = cnt_q - LEN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign msb    = sr_q[WIDTH-1];
  assign last_c = (cnt_q == LEN_W'(1));

endmodule

// File: rtl/seq_gen.sv
// Serial pattern transmitter: sends a captured pattern MSB-first on w, optionally repeated.
// Repetitions and inter-pass gaps exist only when SEQ_GEN_REPEAT_EN is defined.
module seq_gen
  import seq_gen_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned GAP   = 2
) (
  input  logic                      Clock,
  input  logic                      Rn,
  input  logic                      start,
  input  logic [WIDTH-1:0]          pattern,
  input  logic [len_w(WIDTH)-1:0]   len,
  input  logic [REPS_W-1:0]         reps,
  output logic                      w,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned LEN_W = len_w(WIDTH);
  localparam int unsigned GAP_W = cnt_w(GAP);

  logic [STATE_W-1:0] state_d, state_q;
  logic [WIDTH-1:0]   pat_cap_d, pat_cap_q;
  logic [LEN_W-1:0]   len_cap_d, len_cap_q;
  logic               w_d, w_q;
  logic               busy_d, busy_q;
  logic               done_d, done_q;

  logic               sr_load_c;
  logic               sr_shift_c;
  logic [WIDTH-1:0]   sr_data_c;
  logic [LEN_W-1:0]   sr_len_c;
  logic               sr_msb;
  logic               sr_last_c;

  logic [LEN_W-1:0]   len_clamp_c;
  logic [WIDTH-1:0]   pat_align_c;

`ifdef SEQ_GEN_REPEAT_EN
  logic [REPS_W-1:0]  rep_cnt_d, rep_cnt_q;
  logic [GAP_W-1:0]   gap_cnt_d, gap_cnt_q;
`else
  logic               unused_reps_c;
  assign unused_reps_c = ^reps;
`endif

  // Clamp the length and left-align the pattern so bit len-1 lands in the MSB.
  always_comb begin
    len_clamp_c = (len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : len;
    pat_align_c = pattern << (LEN_W'(WIDTH) - len_clamp_c);
  end

  seq_gen_shreg #(
    .WIDTH (WIDTH),
    .LEN_W (LEN_W)
  ) u_shreg (
    .clk       (Clock),
    .rst_n     (Rn),
    .load      (sr_load_c),
    .shift     (sr_shift_c),
    .load_data (sr_data_c),
    .load_len  (sr_len_c),
    .msb       (sr_msb),
    .last_c    (sr_last_c)
  );

  // Next-state, capture and shift-register control.
  always_comb begin
    state_d    = state_q;
    pat_cap_d  = pat_cap_q;
    len_cap_d  = len_cap_q;
    sr_load_c  = 1'b0;
    sr_shift_c = 1'b0;
    sr_data_c  = pat_cap_q;
    sr_len_c   = len_cap_q;
`ifdef SEQ_GEN_REPEAT_EN
    rep_cnt_d  = rep_cnt_q;
    gap_cnt_d  = gap_cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          pat_cap_d = pat_align_c;
          len_cap_d = len_clamp_c;
`ifdef SEQ_GEN_REPEAT_EN
          rep_cnt_d = reps;
`endif
          if (len_clamp_c == '0) begin
            state_d = S_DONE;
          end else begin
            state_d   = S_SHIFT;
            sr_load_c = 1'b1;
            sr_data_c = pat_align_c;
            sr_len_c  = len_clamp_c;
          end
        end
      end

      S_SHIFT: begin
        if (sr_last_c) begin
`ifdef SEQ_GEN_REPEAT_EN
          if (rep_cnt_q != '0) begin
            rep_cnt_d = rep_cnt_q - REPS_W'(1);
            // With no gap the next pass follows back-to-back from the captured copy.
            if (GAP == 0) begin
              sr_load_c = 1'b1;
            end else begin
              state_d   = S_GAP;
              gap_cnt_d = GAP_W'(GAP - 1);
            end
          end else begin
            state_d = S_DONE;
          end
`else
          state_d = S_DONE;
`endif
        end else begin
          sr_shift_c = 1'b1;
        end
      end

`ifdef SEQ_GEN_REPEAT_EN
      S_GAP: begin
        if (gap_cnt_q == '0) begin
          state_d   = S_SHIFT;
          sr_load_c = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
`endif

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    w_d    = (state_q == S_SHIFT) & sr_msb;
    busy_d = (state_q == S_SHIFT) || (state_q == S_GAP);
    done_d = (state_q == S_DONE);
  end

  always_ff @(posedge Clock or negedge Rn) begin
    if (!Rn) begin
      state_q   <= S_IDLE;
      pat_cap_q <= '0;
      len_cap_q <= '0;
      w_q       <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_cap_q <= pat_cap_d;
      len_cap_q <= len_cap_d;
      w_q       <= w_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

`ifdef SEQ_GEN_REPEAT_EN
  always_ff @(posedge Clock or negedge Rn) begin
    if (!Rn) begin
      rep_cnt_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end
`endif

  assign w    = w_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_seq_gen.sv
// Bench for seq_gen: per-cycle queue model of expected w/busy/done plus hand-computed vectors.
module tb_seq_gen;
  import seq_gen_pkg::*;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned GAP   = 2;
  localparam int unsigned LEN_W = len_w(WIDTH);

  logic             Clock;
  logic             Rn;
  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [LEN_W-1:0] len;
  logic [3:0]       reps;
  logic             w, busy, done;

  int n_cmp = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;
  logic [2:0] exp_q[$];
  logic [63:0] wv, bv, dv;

  seq_gen #(.WIDTH(WIDTH), .GAP(GAP)) dut (
    .Clock   (Clock),
    .Rn      (Rn),
    .start   (start),
    .pattern (pattern),
    .len     (len),
    .reps    (reps),
    .w       (w),
    .busy    (busy),
    .done    (done)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  function automatic int eff_reps(input logic [3:0] r);
`ifdef SEQ_GEN_REPEAT_EN
    return int'(r);
`else
    return (r == 4'd15) ? 0 : 0;
`endif
  endfunction

  // Model: on an accepted start, queue {w,busy,done} for every following cycle.
  always @(posedge Clock or negedge Rn) begin
    if (!Rn) begin
      exp_q.delete();
    end else if (start && exp_q.size() == 0) begin
      int n;
      int r;
      n = (int'(len) > int'(WIDTH)) ? int'(WIDTH) : int'(len);
      r = eff_reps(reps);
      exp_q.push_back(3'b000);
      if (n != 0) begin
        for (int p = 0; p <= r; p++) begin
          for (int i = n - 1; i >= 0; i--) exp_q.push_back({pattern[i], 2'b10});
          if (p < r) for (int g = 0; g < int'(GAP); g++) exp_q.push_back(3'b010);
        end
      end
      exp_q.push_back(3'b001);
    end
  end

  always @(negedge Clock) begin
    if (chk_en) begin
      logic [2:0] e;
      e = 3'b000;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      n_cmp++;
      if ({w, busy, done} !== e) begin
        n_bad++;
        $display("FAIL model t=%0t {w,busy,done} got %b expected %b", $time, {w, busy, done}, e);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // Start a run and record outputs for cycles 0..ncyc-1 after the capturing edge (oldest bit is MSB).
  task automatic run_rec(input logic [WIDTH-1:0] pat, input logic [LEN_W-1:0] l,
                         input logic [3:0] r, input int ncyc,
                         output logic [63:0] ow, output logic [63:0] ob, output logic [63:0] od);
    ow = '0; ob = '0; od = '0;
    @(negedge Clock);
    pattern = pat; len = l; reps = r; start = 1'b1;
    @(posedge Clock);
    for (int j = 0; j < ncyc; j++) begin
      @(negedge Clock);
      if (j == 0) start = 1'b0;
      ow = {ow[62:0], w};
      ob = {ob[62:0], busy};
      od = {od[62:0], done};
    end
  endtask

  initial begin
    Rn = 1'b1; start = 1'b0; pattern = '0; len = '0; reps = '0;
    #1 Rn = 1'b0;
    #11;
    check("reset_outputs", 64'({w, busy, done}), 64'b000);
    @(negedge Clock);
    #2 Rn = 1'b1;
    chk_en = 1'b1;

    // Canonical 1101, single pass.
    run_rec(WIDTH'(PAT_1101), 4, 0, 6, wv, bv, dv);
    check("t1_w", wv, 64'b011010);
    check("t1_busy", bv, 64'b011110);
    check("t1_done", dv, 64'b000001);

    // Repeats with gaps (single pass when repeats are not built).
    run_rec(WIDTH'(PAT_1101), 4, 2, 18, wv, bv, dv);
`ifdef SEQ_GEN_REPEAT_EN
    check("t2_w", wv, 64'b011010011010011010);
    check("t2_busy", bv, 64'b011111111111111110);
    check("t2_done", dv, 64'b000000000000000001);
`else
    check("t2_w", wv, 64'b011010000000000000);
    check("t2_busy", bv, 64'b011110000000000000);
    check("t2_done", dv, 64'b000001000000000000);
`endif

    // Zero length: immediate done, never busy.
    run_rec(8'hFF, 0, 0, 4, wv, bv, dv);
    check("t3_w", wv, 64'b0000);
    check("t3_busy", bv, 64'b0000);
    check("t3_done", dv, 64'b0100);

    // Start and pattern change mid-send are ignored.
    wv = '0; dv = '0;
    @(negedge Clock);
    pattern = 8'hA5; len = 8; reps = 0; start = 1'b1;
    @(posedge Clock);
    for (int j = 0; j < 10; j++) begin
      @(negedge Clock);
      if (j == 0) start = 1'b0;
      if (j == 2) begin start = 1'b1; pattern = 8'hFF; end
      if (j == 3) start = 1'b0;
      wv = {wv[62:0], w};
      dv = {dv[62:0], done};
    end
    check("t4_w", wv, 64'b0101001010);
    check("t4_done", dv, 64'b0000000001);

    // Length above WIDTH clamps; bits above len are not sent.
    run_rec(8'h81, 15, 0, 10, wv, bv, dv);
    check("t5_w", wv, 64'b0100000010);
    check("t5_done", dv, 64'b0000000001);
    run_rec(8'hFD, 3, 0, 5, wv, bv, dv);
    check("t6_w", wv, 64'b01010);
    check("t6_done", dv, 64'b00001);

    // start held high restarts after each done.
    wv = '0; bv = '0; dv = '0;
    @(negedge Clock);
    pattern = 8'h02; len = 2; reps = 0; start = 1'b1;
    @(posedge Clock);
    for (int j = 0; j < 9; j++) begin
      @(negedge Clock);
      wv = {wv[62:0], w};
      bv = {bv[62:0], busy};
      dv = {dv[62:0], done};
    end
    start = 1'b0;
    check("t7_w", wv, 64'b010001000);
    check("t7_busy", bv, 64'b011001100);
    check("t7_done", dv, 64'b000100010);
    repeat (6) @(negedge Clock);

    // Reset during the third bit.
    @(negedge Clock);
    pattern = 8'hFF; len = 8; reps = 0; start = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    start = 1'b0;
    repeat (3) @(negedge Clock);
    check("t8_pre_w_busy", 64'({w, busy}), 64'b11);
    #2 Rn = 1'b0;
    #1 check("t8_async_outputs", 64'({w, busy, done}), 64'b000);
    repeat (3) @(negedge Clock);
    #2 Rn = 1'b1;
    repeat (3) @(negedge Clock);
    check("t8_idle_after", 64'({w, busy, done}), 64'b000);
    run_rec(WIDTH'(PAT_1101), 4, 0, 6, wv, bv, dv);
    check("t8_resend_w", wv, 64'b011010);
    check("t8_resend_done", dv, 64'b000001);

    // Longer repeated run, checked by the model only.
    run_rec(8'h3C, 6, 3, 40, wv, bv, dv);
    repeat (4) @(negedge Clock);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
